ring_demux_1x3: RTL
===================

// Module: ring_demux_1x3
// PURPOSE
//   Receive end of the 3-slot time-multiplexed line driven by the 3x1 ring-counter mux.
//   An internal one-hot ring counter walks slots 0->1->2, each slot lasting DIV clocks.
//   The shared line is sampled on the last clock of each slot into that slot's hold register.
//   ring_counter is exported so the transmit-side mux can run off the same slot select.
// PARAMETERS
//   WIDTH  1  bits per channel / width of data_in
//   DIV    4  clocks per slot; legal range 1..256
// PORTS
//   clk           in   1      system clock, rising edge
//   rst_n         in   1      synchronous reset, active low
//   enable        in   1      1: prescaler/ring advance; 0: freeze all state
//   clear         in   1      synchronous restart of the frame, see BEHAVIOUR
//   data_in       in   WIDTH  shared multiplexed line
//   ring_counter  out  3      one-hot slot select; bit k = slot k
//   ch_2          out  WIDTH  held value of slot 2
//   ch_1          out  WIDTH  held value of slot 1
//   ch_0          out  WIDTH  held value of slot 0
//   valid         out  3      sticky per-slot "captured since reset/clear"
//   frame_done    out  1      1-cycle pulse, slot 2 just captured
//   ring_error    out  1      1-cycle pulse, illegal ring state repaired
// BEHAVIOUR
//   - All outputs are registered. Reset (rst_n=0 at clk edge):
//     ring_counter=3'b001, prescaler=0, ch_*=0, valid=0, frame_done=0, ring_error=0.
//   - Priority per edge: rst_n > clear > ring repair > enable-driven advance > hold.
//   - Prescaler cnt, width max(1,$clog2(DIV)), counts 0..DIV-1 while enable=1.
//   - Slot end = enable && cnt==DIV-1. On that edge:
//     ch_k<=data_in for the set bit k; valid[k]<=1; cnt<=0;
//     ring rotates left 001->010->100->001.
//   - frame_done is 1 on the cycle after slot 2 captures, i.e. same cycle the new ch_2 is
//     visible; otherwise 0. Never asserted for slots 0/1.
//   - enable=0: cnt, ring, ch_*, valid hold. frame_done drops to 0.
//     Deasserting mid-slot resumes from the same cnt.
//   - clear=1: ring<=001, cnt<=0, valid<=0, ch_*<=0, frame_done<=0. clear wins over a
//     coincident slot end; no capture happens that edge.
//   - DIV=1: every enabled clock is a slot end. Frame = 3 clocks.
//   - Data latency: data_in at slot-end edge appears on ch_k 1 clock later.
//   - Reset or clear mid-slot discards the partial slot. Next frame starts at slot 0, cnt 0.
// CONFIGURATION
//   RING_DEMUX_ONEHOT_CHECK_EN defined:
//   - Each cycle, if ring_counter is not exactly one-hot (000, 011, 101, 110, 111):
//     next edge forces ring<=001 and cnt<=0; no capture that edge.
//   - ring_error pulses 1 cycle; ch_* and valid are kept.
//   - Checked even when enable=0.
//   Undefined: no check logic, ring_error tied 0; illegal states rotate as-is.
// STRUCTURE
//   - Package ring_demux_pkg:
//     N_SLOTS=3; RING_RESET=3'b001;
//     function is_onehot3(input [2:0]);
//     function rotl3(input [2:0]).
//   - Sub-module prescaled_ring_counter_3 (DIV param): cnt, ring, slot_end strobe, repair/clear
//     inputs. Top holds the capture registers, valid, frame_done.
// TESTING
//   1. Reset, enable=1, DIV=4, WIDTH=8, data_in=8'hA1/B2/C3 per slot ->
//      ch_0=A1 @ clk5, ch_1=B2 @ clk9, ch_2=C3 + frame_done=1 @ clk13; ring 001,010,100,001.
//   2. enable=0 for 5 clocks at cnt=2 of slot 1 ->
//      ring=010 and ch_* frozen; capture at clk 5+2 later than nominal.
//   3. clear on the exact slot-2 end edge ->
//      no capture, ring=001, valid=0, ch_*=0, frame_done stays 0.
//   4. DIV=1, data_in toggles 1,0,1 ->
//      ch_0=1, ch_1=0, ch_2=1 after 3 enabled clocks; frame_done every 3rd clock.
//   5. rst_n=0 mid-frame with valid=3'b011 ->
//      next cycle all outputs at reset values; first capture DIV clocks after release.
//   6. Macro on, force ring=3'b110 ->
//      next clk ring=001, cnt=0, ring_error 1-cycle pulse, ch_* unchanged;
//      macro off: ring_error=0.

Source files
------------

// File: rtl/ring_demux_pkg.sv
// Shared types and helpers for the 3-slot ring-counter demultiplexer.
package ring_demux_pkg;

  localparam int N_SLOTS = 3;

  typedef logic [N_SLOTS-1:0] ring_t;

  localparam ring_t RING_RESET = 3'b001;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic logic [2:0] rotl3(input logic [2:0] v);
    return {v[1:0], v[2]};
  endfunction

endpackage

// File: rtl/ring_demux_1x3_ring.sv
// Prescaled one-hot slot counter: each slot lasts DIV enabled clocks, then the ring
// rotates left. Clear and repair both restart the frame at slot 0, cnt 0.
module prescaled_ring_counter_3
  import ring_demux_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_enable,
  input  logic  i_clear,
  input  logic  i_repair,
  output ring_t o_ring,
  output logic  o_slot_end
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  ring_t         r_ring;
  logic          w_tc;

  assign w_tc = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ring <= RING_RESET;
      r_cnt  <= '0;
    end else if (i_clear || i_repair) begin
      r_ring <= RING_RESET;
      r_cnt  <= '0;
    end else if (i_enable && w_tc) begin
      r_ring <= rotl3(r_ring);
      r_cnt  <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Strobe is already qualified so the top never captures on a restart edge.
  assign o_slot_end = i_enable && w_tc && !i_clear && !i_repair;
  assign o_ring     = r_ring;

endmodule

// File: rtl/ring_demux_1x3.sv
// Receive side of the 3-slot time-multiplexed line: per-slot hold registers, sticky
// valid, frame_done pulse. Optional one-hot ring repair under RING_DEMUX_ONEHOT_CHECK_EN.
module ring_demux_1x3
  import ring_demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DIV   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data_in,
  output logic [2:0]       o_ring_counter,
  output logic [WIDTH-1:0] o_ch_2,
  output logic [WIDTH-1:0] o_ch_1,
  output logic [WIDTH-1:0] o_ch_0,
  output logic [2:0]       o_valid,
  output logic             o_frame_done,
  output logic             o_ring_error
);

  ring_t            w_ring;
  logic             w_slot_end;
  logic             w_repair;
  logic [WIDTH-1:0] r_ch [N_SLOTS];
  logic [2:0]       r_valid;
  logic             r_frame_done;

  prescaled_ring_counter_3 #(.DIV(DIV)) u_ring (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enable   (i_enable),
    .i_clear    (i_clear),
    .i_repair   (w_repair),
    .o_ring     (w_ring),
    .o_slot_end (w_slot_end)
  );

`ifdef RING_DEMUX_ONEHOT_CHECK_EN
  logic r_ring_error;

  // Checked regardless of enable; clear outranks repair.
  assign w_repair = !is_onehot3(w_ring) && !i_clear;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_ring_error <= 1'b0;
    else          r_ring_error <= w_repair;
  end

  assign o_ring_error = r_ring_error;
`else
  assign w_repair     = 1'b0;
  assign o_ring_error = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      for (int k = 0; k < N_SLOTS; k++) r_ch[k] <= '0;
      r_valid      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_slot_end && w_ring[2];
      if (w_slot_end) begin
        // Every set bit captures, so an unrepaired illegal ring fans data out as-is.
        for (int k = 0; k < N_SLOTS; k++) begin
          if (w_ring[k]) begin
            r_ch[k]    <= i_data_in;
            r_valid[k] <= 1'b1;
          end
        end
      end
    end
  end

  assign o_ring_counter = w_ring;
  assign o_ch_0         = r_ch[0];
  assign o_ch_1         = r_ch[1];
  assign o_ch_2         = r_ch[2];
  assign o_valid        = r_valid;
  assign o_frame_done   = r_frame_done;

endmodule
